// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder/subtractor.
//
// Contents:
//   state_e   - FSM state encoding (IDLE, CALC, DONE)
//   numChunks - number of CHUNK-bit slices in a WIDTH-bit operand
//   cntWidth  - slice counter width, never narrower than one bit
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int numChunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a one-bit counter so that
    // the counter register and its compare stay well-formed.
    function automatic int cntWidth(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// One CHUNK-bit combinational ripple-carry slice built from full adders.
//
// Ports:
//   x, y      - CHUNK-bit slice operands
//   ci        - carry into bit 0
//   s         - CHUNK-bit slice sum
//   co        - carry out of the top bit
//   c_msb_in  - carry into the top bit (for signed overflow detection)
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
    end

    assign co       = carry[CHUNK];
    assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that pushes one CHUNK-bit slice per
// clock through a single ripple slice. Optional accumulate mode feeds the
// held result back in as operand A.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake
//   a, b, cin           - operands and carry-in (cin ignored when subtracting)
//   sub                 - 1: A - B, 0: A + B + cin
//   acc_en              - 1: operand A is the held result register
//   out_valid, out_ready- result handshake
//   sum, cout, overflow - result, carry out of MSB (no-borrow when
//                         subtracting), signed overflow
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = numChunks(WIDTH, CHUNK);
    localparam int CNTW   = cntWidth(NCHUNK);
    localparam logic [CNTW-1:0] LAST_SLICE = CNTW'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  opA_q, opA_d;
    logic [WIDTH-1:0]  opB_q, opB_d;
    logic              carry_q, carry_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              overflow_q, overflow_d;

    int                sliceLsb;
    logic [CHUNK-1:0]  sliceA, sliceB, sliceSum;
    logic              sliceCo, sliceMsbIn;

    // The counter selects which slice of the captured operands feeds the
    // shared ripple slice this cycle.
    assign sliceLsb = int'(count_q) * CHUNK;
    assign sliceA   = opA_q[sliceLsb +: CHUNK];
    assign sliceB   = opB_q[sliceLsb +: CHUNK];

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x        (sliceA),
        .y        (sliceB),
        .ci       (carry_q),
        .s        (sliceSum),
        .co       (sliceCo),
        .c_msb_in (sliceMsbIn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opA_q      <= '0;
            opB_q      <= '0;
            carry_q    <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            carry_q    <= carry_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    // Subtraction is A + ~B + 1, so capture inverts B and forces the
    // initial carry. In the final slice the carry into its top bit is the
    // carry into the word MSB, which gives signed overflow.
    always_comb begin
        state_d    = state_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        carry_d    = carry_q;
        count_d    = count_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opA_d   = acc_en ? sum_q : a;
                    opB_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[sliceLsb +: CHUNK] = sliceSum;
                carry_d = sliceCo;
                count_d = count_q + CNTW'(1);
                if (count_q == LAST_SLICE) begin
                    cout_d     = sliceCo;
                    overflow_d = sliceCo ^ sliceMsbIn;
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (CHUNK = 4, 1, 16) share
// clock, reset and operand buses; each has its own handshake. Expected
// results come from a behavioural add/subtract model and travel through a
// scoreboard queue from stimulus to output.
module tb_chunked_serial_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic        acc;
    } op_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin, sub, accEn;
    logic [2:0]  inValid, inReady, outValid, outReady, coutO, ovfO;
    logic [15:0] sumO [3];

    int          checks = 0;
    int          errors = 0;
    exp_t        expQ[$];
    logic [15:0] accModel [3];
    int          nch [3] = '{4, 16, 1};

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(accEn),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .sum(sumO[0]), .cout(coutO[0]), .overflow(ovfO[0])
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(accEn),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .sum(sumO[1]), .cout(coutO[1]), .overflow(ovfO[1])
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(accEn),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .sum(sumO[2]), .cout(coutO[2]), .overflow(ovfO[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic op_t mkOp(input logic [15:0] oa, input logic [15:0] ob,
                                 input logic oc, input logic os, input logic oacc);
        op_t o;
        o.a = oa; o.b = ob; o.cin = oc; o.sub = os; o.acc = oacc;
        return o;
    endfunction

    // Computes the expected result, pushes it to the scoreboard, then holds
    // in_valid until the selected instance accepts (bounded).
    task automatic applyStimulus(input int sel, input op_t op, output bit accepted);
        logic [15:0] aEff, bEff;
        logic [16:0] full;
        exp_t        e;
        aEff   = op.acc ? accModel[sel] : op.a;
        bEff   = op.sub ? ~op.b : op.b;
        full   = {1'b0, aEff} + {1'b0, bEff} + (op.sub ? 17'd1 : {16'd0, op.cin});
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (aEff[15] == bEff[15]) && (full[15] != aEff[15]);
        accModel[sel] = e.sum;
        expQ.push_back(e);
        a = op.a; b = op.b; cin = op.cin; sub = op.sub; accEn = op.acc;
        inValid[sel] = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (inReady[sel] === 1'b1) accepted = 1'b1;
            @(posedge clk); #1;
        end
        inValid[sel] = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid (bounded).
    task automatic waitResult(input int sel, output int lat);
        lat = 0;
        while (outValid[sel] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (inReady[s] !== 1'b1 || outValid[s] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_handshake dut%0d: in_ready=%b out_valid=%b, required 1 0",
                         s, inReady[s], outValid[s]);
            end
            checks++;
            if (sumO[s] !== 16'h0 || coutO[s] !== 1'b0 || ovfO[s] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_result dut%0d: sum=%h cout=%b ovf=%b, required 0000 0 0",
                         s, sumO[s], coutO[s], ovfO[s]);
            end
        end
    endtask

    // Runs a list of operations on one instance and checks each result,
    // its latency and the return to IDLE after consumption.
    task automatic test_ops(input int sel, input string name, input op_t ops[$]);
        bit   ok;
        int   lat;
        exp_t e;
        foreach (ops[i]) begin
            applyStimulus(sel, ops[i], ok);
            waitResult(sel, lat);
            checks++;
            if (!ok || lat !== nch[sel]) begin
                errors++;
                $display("[TB] FAIL %s[%0d] latency: accepted=%0b edges=%0d, required %0d",
                         name, i, ok, lat, nch[sel]);
            end
            if (expQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL %s[%0d] scoreboard: queue empty, required one entry", name, i);
            end else begin
                e = expQ.pop_front();
                checks++;
                if (sumO[sel] !== e.sum) begin
                    errors++;
                    $display("[TB] FAIL %s[%0d] sum: got %h, required %h", name, i, sumO[sel], e.sum);
                end
                checks++;
                if (coutO[sel] !== e.cout || ovfO[sel] !== e.ovf) begin
                    errors++;
                    $display("[TB] FAIL %s[%0d] flags: cout=%b ovf=%b, required cout=%b ovf=%b",
                             name, i, coutO[sel], ovfO[sel], e.cout, e.ovf);
                end
            end
            outReady[sel] = 1'b1;
            @(posedge clk); #1;
            outReady[sel] = 1'b0;
            checks++;
            if (inReady[sel] !== 1'b1 || outValid[sel] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s[%0d] consume: in_ready=%b out_valid=%b, required 1 0",
                         name, i, inReady[sel], outValid[sel]);
            end
        end
    endtask

    task automatic test_add();
        op_t ops[$];
        ops.push_back(mkOp(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0));
        ops.push_back(mkOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0));
        ops.push_back(mkOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0));
        ops.push_back(mkOp(16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b0));
        test_ops(0, "add", ops);
    endtask

    task automatic test_sub();
        op_t ops[$];
        ops.push_back(mkOp(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0));
        ops.push_back(mkOp(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0));
        test_ops(0, "sub", ops);
    endtask

    task automatic test_accumulate();
        op_t ops[$];
        ops.push_back(mkOp(16'hAAAA, 16'h0010, 1'b0, 1'b0, 1'b1));
        ops.push_back(mkOp(16'h5555, 16'h0001, 1'b0, 1'b0, 1'b1));
        ops.push_back(mkOp(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b1));
        test_ops(0, "accumulate", ops);
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        exp_t e;
        applyStimulus(0, mkOp(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0), ok);
        waitResult(0, lat);
        checks++;
        if (!ok || lat !== nch[0]) begin
            errors++;
            $display("[TB] FAIL backpressure latency: accepted=%0b edges=%0d, required %0d", ok, lat, nch[0]);
        end
        e = expQ.pop_front();
        for (int i = 0; i < 5; i++) begin
            inValid[0] = ~inValid[0];
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b, required 1 0",
                         i, outValid[0], inReady[0]);
            end
            checks++;
            if (sumO[0] !== e.sum || coutO[0] !== e.cout || ovfO[0] !== e.ovf) begin
                errors++;
                $display("[TB] FAIL backpressure_stable[%0d]: sum=%h cout=%b ovf=%b, required %h %b %b",
                         i, sumO[0], coutO[0], ovfO[0], e.sum, e.cout, e.ovf);
            end
        end
        inValid[0] = 1'b0;
        outReady[0] = 1'b1;
        @(posedge clk); #1;
        outReady[0] = 1'b0;
        checks++;
        if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || sumO[0] !== e.sum) begin
            errors++;
            $display("[TB] FAIL backpressure_release: out_valid=%b in_ready=%b sum=%h, required 0 1 %h",
                     outValid[0], inReady[0], sumO[0], e.sum);
        end
        @(posedge clk); #1;
        checks++;
        if (inReady[0] !== 1'b1 || sumO[0] !== e.sum) begin
            errors++;
            $display("[TB] FAIL backpressure_idle: in_ready=%b sum=%h, required 1 %h",
                     inReady[0], sumO[0], e.sum);
        end
    endtask

    task automatic test_reset_mid_calc();
        bit  ok;
        bit  sawValid;
        op_t ops[$];
        applyStimulus(0, mkOp(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0), ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sumO[0] !== 16'h0 || coutO[0] !== 1'b0 || ovfO[0] !== 1'b0 ||
            outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midcalc_reset: sum=%h cout=%b ovf=%b out_valid=%b in_ready=%b, required 0000 0 0 0 1",
                     sumO[0], coutO[0], ovfO[0], outValid[0], inReady[0]);
        end
        void'(expQ.pop_back());
        for (int s = 0; s < 3; s++) accModel[s] = 16'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (outValid[0] === 1'b1) sawValid = 1'b1;
        end
        checks++;
        if (sawValid) begin
            errors++;
            $display("[TB] FAIL midcalc_no_valid: out_valid pulsed=1, required 0");
        end
        ops.push_back(mkOp(16'hBEEF, 16'h0003, 1'b0, 1'b0, 1'b1));
        test_ops(0, "acc_after_reset", ops);
    endtask

    task automatic test_chunk_variants();
        op_t ops[$];
        ops.push_back(mkOp(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0));
        ops.push_back(mkOp(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0));
        test_ops(1, "chunk1", ops);
        test_ops(2, "chunk16", ops);
    endtask

    initial begin
        rst_n = 1'b1;
        inValid = '0; outReady = '0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; accEn = 1'b0;
        for (int s = 0; s < 3; s++) accModel[s] = 16'h0;
        #1 rst_n = 1'b0;
        #11;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_accumulate();
        test_backpressure();
        test_reset_mid_calc();
        test_chunk_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
